// File: rtl/view_pkg.sv
// Shared types and helpers for the video view switch.
package view_pkg;

   typedef logic [11:0] rgb444_t;

   typedef enum logic {
      RUN     = 1'b0,
      PENDING = 1'b1
   } view_state_e;

   localparam rgb444_t FILL_DEFAULT = 12'h000;

   function automatic rgb444_t gray_to_rgb444(input logic [3:0] n);
      return {n, n, n};
   endfunction

endpackage

// File: rtl/view_pix_fmt.sv
// Per-source pixel format converter: gray (top nibble replicated) or RGB444 pass-through.
module view_pix_fmt
   import view_pkg::*;
#(
   parameter bit          GRAY_IS = 1'b0,
   parameter int unsigned GRAY_W  = 8
) (
   input  rgb444_t din,
   output rgb444_t dout
);

   logic unused_din;

   if (GRAY_IS) begin : g_gray
      assign dout       = gray_to_rgb444(din[GRAY_W-1 -: 4]);
      assign unused_din = ^din;
   end else begin : g_rgb
      assign dout       = din;
      assign unused_din = 1'b0;
   end

endmodule

// File: rtl/video_view_switch.sv
// N-source pixel view selector feeding vga_driver; view changes land only on frame boundaries.
// Optional build macro VIEW_DRAIN_IDLE_EN keeps idle sources drained and frame-aligned.
module video_view_switch
   import view_pkg::*;
#(
   parameter int unsigned        NUM_SRC       = 4,
   parameter int unsigned        GRAY_W        = 8,
   parameter logic [NUM_SRC-1:0] SRC_GRAY_MASK = 4'b0110,
   parameter int unsigned        FRAME_PIXELS  = 307200,
   parameter int unsigned        DEFAULT_SEL   = 0,
   parameter logic [11:0]        FILL_RGB      = FILL_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(NUM_SRC)-1:0] sel_req,
   input  logic [NUM_SRC-1:0]         src_valid,
   output logic [NUM_SRC-1:0]         src_ready,
   input  logic [NUM_SRC*12-1:0]      src_data,
   input  logic                       out_ready,
   output logic [11:0]                out_data,
   output logic                       frame_start,
   output logic [$clog2(NUM_SRC)-1:0] sel_active,
   output logic                       switch_pending,
   output logic                       underrun
);

   localparam int unsigned      SEL_W    = $clog2(NUM_SRC);
   localparam int unsigned      CNT_W    = $clog2(FRAME_PIXELS);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [SEL_W-1:0] RST_SEL  = SEL_W'(DEFAULT_SEL);

   rgb444_t          fmt_data [NUM_SRC];
   view_state_e      state;
   logic [CNT_W-1:0] pix_cnt;
   logic [SEL_W-1:0] sel_tgt;
   logic [SEL_W-1:0] sel_next_tgt;
   logic             sel_ok;
   logic             boundary;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fmt
      view_pix_fmt #(
         .GRAY_IS (SRC_GRAY_MASK[g]),
         .GRAY_W  (GRAY_W)
      ) u_fmt (
         .din  (src_data[g*12 +: 12]),
         .dout (fmt_data[g])
      );
   end

   always_comb begin
      src_ready = '0;
`ifdef VIEW_DRAIN_IDLE_EN
      src_ready = {NUM_SRC{out_ready}};
`else
      src_ready[sel_active] = out_ready;
`endif
   end

   // Out-of-range requests are ignored: while pending, the last valid target is kept.
   always_comb begin
      sel_ok       = (32'(sel_req) < NUM_SRC);
      sel_next_tgt = sel_ok ? sel_req : sel_tgt;
      boundary     = out_ready && (pix_cnt == LAST_PIX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data       <= FILL_RGB;
         frame_start    <= 1'b0;
         sel_active     <= RST_SEL;
         sel_tgt        <= RST_SEL;
         switch_pending <= 1'b0;
         underrun       <= 1'b0;
         pix_cnt        <= '0;
         state          <= RUN;
      end else begin
         if (out_ready) begin
            out_data    <= src_valid[sel_active] ? fmt_data[sel_active] : FILL_RGB;
            frame_start <= (pix_cnt == '0);
            pix_cnt     <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
            if (!src_valid[sel_active]) begin
               underrun <= 1'b1;
            end
         end else begin
            frame_start <= 1'b0;
         end

         sel_tgt <= sel_next_tgt;
         case (state)
            RUN: begin
               if (sel_ok && (sel_req != sel_active)) begin
                  state          <= PENDING;
                  switch_pending <= 1'b1;
               end
            end
            PENDING: begin
               if (sel_next_tgt == sel_active) begin
                  state          <= RUN;
                  switch_pending <= 1'b0;
               end else if (boundary) begin
                  sel_active     <= sel_next_tgt;
                  state          <= RUN;
                  switch_pending <= 1'b0;
               end
            end
            default: begin
               state          <= RUN;
               switch_pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_view_switch.sv
// Directed scoreboard bench for video_view_switch (4 sources, 16-pixel frames).
module tb_video_view_switch;

   typedef struct packed {
      logic [11:0] out;
      logic        fs;
      logic [1:0]  sel;
      logic        pend;
      logic        und;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel_req;
   logic [3:0]  src_valid;
   logic [3:0]  src_ready;
   logic [47:0] src_data;
   logic        out_ready;
   logic [11:0] out_data;
   logic        frame_start;
   logic [1:0]  sel_active;
   logic        switch_pending;
   logic        underrun;

   logic [11:0] src_d [4];

   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t        sb [$];

   // reference model state
   logic [11:0] m_out;
   logic        m_fs;
   logic [1:0]  m_sel;
   logic        m_pend;
   logic        m_und;
   int unsigned m_cnt;

   assign src_data = {src_d[3], src_d[2], src_d[1], src_d[0]};

   always #5 clk = ~clk;

   video_view_switch #(
      .NUM_SRC       (4),
      .GRAY_W        (8),
      .SRC_GRAY_MASK (4'b0110),
      .FRAME_PIXELS  (16),
      .DEFAULT_SEL   (0),
      .FILL_RGB      (12'h000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sel_req        (sel_req),
      .src_valid      (src_valid),
      .src_ready      (src_ready),
      .src_data       (src_data),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .frame_start    (frame_start),
      .sel_active     (sel_active),
      .switch_pending (switch_pending),
      .underrun       (underrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] fmt(input int unsigned s);
      logic [11:0] d;
      d = src_d[s];
      if (s == 1 || s == 2) return {d[7:4], d[7:4], d[7:4]};
      return d;
   endfunction

   task automatic step();
      exp_t        e;
      logic [3:0]  exp_rdy;
      int unsigned cur;
      int unsigned cnt;
      #1;
`ifdef VIEW_DRAIN_IDLE_EN
      exp_rdy = {4{out_ready}};
`else
      exp_rdy = out_ready ? (4'b0001 << m_sel) : 4'b0000;
`endif
      check("src_ready", {28'd0, src_ready}, {28'd0, exp_rdy});

      if (rst) begin
         m_out = 12'h000; m_fs = 1'b0; m_sel = 2'd0;
         m_pend = 1'b0; m_und = 1'b0; m_cnt = 0;
      end else begin
         cur = m_sel;
         cnt = m_cnt;
         if (out_ready) begin
            m_out = src_valid[cur] ? fmt(cur) : 12'h000;
            if (!src_valid[cur]) m_und = 1'b1;
            m_fs  = (cnt == 0);
            m_cnt = (cnt == 15) ? 0 : cnt + 1;
         end else begin
            m_fs = 1'b0;
         end
         if (!m_pend) begin
            if (sel_req != m_sel) m_pend = 1'b1;
         end else if (sel_req == m_sel) begin
            m_pend = 1'b0;
         end else if (out_ready && cnt == 15) begin
            m_sel  = sel_req;
            m_pend = 1'b0;
         end
      end
      e = '{out: m_out, fs: m_fs, sel: m_sel, pend: m_pend, und: m_und};
      sb.push_back(e);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed 0 expected 1");
      end else begin
         e = sb.pop_front();
         check("out_data",       {20'd0, out_data},       {20'd0, e.out});
         check("frame_start",    {31'd0, frame_start},    {31'd0, e.fs});
         check("sel_active",     {30'd0, sel_active},     {30'd0, e.sel});
         check("switch_pending", {31'd0, switch_pending}, {31'd0, e.pend});
         check("underrun",       {31'd0, underrun},       {31'd0, e.und});
      end
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int unsigned c);
      for (int unsigned i = 0; i < 40 && m_cnt != c; i++) step();
      if (m_cnt != c) begin
         errors++;
         $error("FAIL align observed %0d expected %0d", m_cnt, c);
      end
   endtask

   initial begin
      rst       = 1'b1;
      sel_req   = 2'd0;
      src_valid = 4'b1111;
      out_ready = 1'b0;
      src_d[0]  = 12'hABC;
      src_d[1]  = 12'h0F3;
      src_d[2]  = 12'h055;
      src_d[3]  = 12'h123;
      m_out = 12'h000; m_fs = 1'b0; m_sel = 2'd0;
      m_pend = 1'b0; m_und = 1'b0; m_cnt = 0;

      // reset
      step();
      check("rst_out", {20'd0, out_data}, 32'h000);
      check("rst_sel", {30'd0, sel_active}, 32'd0);

      // steady stream from source 0
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      check("first_pix", {20'd0, out_data}, 32'hABC);
      check("first_fs", {31'd0, frame_start}, 32'd1);
      run(20);

      // switch to gray source 1 at beat 5
      run_to(5);
      sel_req = 2'd1;
      step();
      check("sw1_pending", {31'd0, switch_pending}, 32'd1);
      run(10);
      check("sw1_sel", {30'd0, sel_active}, 32'd1);
      step();
      check("sw1_out", {20'd0, out_data}, 32'hFFF);
      check("sw1_fs", {31'd0, frame_start}, 32'd1);

      // back to 0
      sel_req = 2'd0;
      run_to(15);
      step();
      check("back0_sel", {30'd0, sel_active}, 32'd0);

      // 0 -> 2 -> 0 within one frame
      run_to(3);
      sel_req = 2'd2;
      step();
      check("cancel_rise", {31'd0, switch_pending}, 32'd1);
      run_to(6);
      sel_req = 2'd0;
      step();
      check("cancel_fall", {31'd0, switch_pending}, 32'd0);
      run_to(15);
      step();
      check("cancel_sel", {30'd0, sel_active}, 32'd0);

      // request first seen on the boundary beat
      run_to(15);
      sel_req = 2'd3;
      step();
      check("late_sel", {30'd0, sel_active}, 32'd0);
      check("late_pending", {31'd0, switch_pending}, 32'd1);
      run(15);
      check("late_hold", {30'd0, sel_active}, 32'd0);
      step();
      check("late_sel3", {30'd0, sel_active}, 32'd3);
      step();
      check("late_out3", {20'd0, out_data}, 32'h123);

      sel_req = 2'd0;
      run_to(15);
      step();

      // underrun on beat 7
      run_to(7);
      src_valid[0] = 1'b0;
      step();
      src_valid[0] = 1'b1;
      check("udr_out", {20'd0, out_data}, 32'h000);
      check("udr_flag", {31'd0, underrun}, 32'd1);
      run(18);
      check("udr_sticky", {31'd0, underrun}, 32'd1);

      // out_ready gaps
      out_ready = 1'b0;
      run(2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      out_ready = 1'b1;
      run(3);

      // reset mid-frame with a switch pending
      run_to(6);
      sel_req = 2'd2;
      run_to(9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sel_req = 2'd0;
      check("rst2_out", {20'd0, out_data}, 32'h000);
      check("rst2_pending", {31'd0, switch_pending}, 32'd0);
      check("rst2_underrun", {31'd0, underrun}, 32'd0);
      check("rst2_fs", {31'd0, frame_start}, 32'd0);
      step();
      check("rst2_fs_first", {31'd0, frame_start}, 32'd1);
      run(18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
